// File: rtl/bf16_dot_seq.sv
// Sequencer around an external combinational bf16 FMA. It streams (a, b) pairs
// into the FMA, feeds the accumulator back as the addend, and presents the final sum.
module bf16_dot_seq #(
    parameter int LEN_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic [15:0]      c_init,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_a,
    input  logic [15:0]      in_b,
    output logic [15:0]      fma_a,
    output logic [15:0]      fma_b,
    output logic [15:0]      fma_c,
    input  logic [15:0]      fma_result,
    input  logic             fma_ov,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_result,
    output logic             out_ov
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [15:0]      acc_q, acc_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             ov_q, ov_d;
    logic             accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            acc_q   <= 16'h0000;
            cnt_q   <= '0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ov_q    <= ov_d;
        end
    end

    // Handshake outputs depend on registered state only.
    assign in_ready   = (state_q == ST_RUN);
    assign busy       = (state_q != ST_IDLE);
    assign out_valid  = (state_q == ST_DONE);
    assign out_result = acc_q;
    assign out_ov     = ov_q;

    assign fma_a  = in_ready ? in_a : 16'h0000;
    assign fma_b  = in_ready ? in_b : 16'h0000;
    assign fma_c  = acc_q;
    assign accept = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ov_d    = ov_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    acc_d   = c_init;
                    cnt_d   = len;
                    ov_d    = 1'b0;
                    state_d = (len != '0) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    acc_d = fma_result;
                    ov_d  = ov_q | fma_ov;
                    cnt_d = cnt_q - 1'b1;
                    // Leaving at a count of one means cnt never wraps.
                    if (cnt_q == {{(LEN_W-1){1'b0}}, 1'b1}) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_bf16_dot_seq.sv
// Directed bench for bf16_dot_seq; the external FMA is a lookup table of the
// exact bf16 results for the vectors used below.
module tb_bf16_dot_seq;

    localparam int LEN_W = 5;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [LEN_W-1:0] len;
    logic [15:0]      c_init;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      in_a, in_b;
    logic [15:0]      fma_a, fma_b, fma_c;
    logic [15:0]      fma_result;
    logic             fma_ov;
    logic             busy;
    logic             out_valid;
    logic             out_ready;
    logic [15:0]      out_result;
    logic             out_ov;

    int errors = 0;
    int checks = 0;

    bf16_dot_seq #(.LEN_W(LEN_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .len        (len),
        .c_init     (c_init),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .fma_a      (fma_a),
        .fma_b      (fma_b),
        .fma_c      (fma_c),
        .fma_result (fma_result),
        .fma_ov     (fma_ov),
        .busy       (busy),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_ov     (out_ov)
    );

    always #5 clk = ~clk;

    // a*b+c for the operand triples of this bench; anything else yields a marker value.
    always_comb begin
        fma_result = 16'hDEAD;
        fma_ov     = 1'b0;
        case ({fma_a, fma_b, fma_c})
            48'h3F80_4000_0000: fma_result = 16'h4000; // 1*2+0 = 2
            48'h4000_4040_4000: fma_result = 16'h4100; // 2*3+2 = 8
            48'h3F00_4000_3F80: fma_result = 16'h4000; // 0.5*2+1 = 2
            48'h3F00_4000_4000: fma_result = 16'h4040; // 0.5*2+2 = 3
            48'h3F00_4000_4040: fma_result = 16'h4080; // 0.5*2+3 = 4
            48'h7F00_7F00_0000: begin fma_result = 16'h7F80; fma_ov = 1'b1; end
            48'h3F80_3F80_7F80: fma_result = 16'h7F80; // 1*1+inf = inf
            48'h4000_4040_0000: fma_result = 16'h40C0; // 2*3+0 = 6
            default: begin
                if (fma_a == 16'h0000 && fma_b == 16'h0000) fma_result = fma_c;
            end
        endcase
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle 1 time unit later, away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_flags(input string tag, input logic rdy, input logic bsy, input logic ov_valid);
        chk({tag, ".in_ready"}, {15'b0, in_ready}, {15'b0, rdy});
        chk({tag, ".busy"}, {15'b0, busy}, {15'b0, bsy});
        chk({tag, ".out_valid"}, {15'b0, out_valid}, {15'b0, ov_valid});
    endtask

    task automatic begin_run(input logic [LEN_W-1:0] n, input logic [15:0] c);
        start = 1'b1; len = n; c_init = c;
        tick();
        start = 1'b0;
    endtask

    task automatic pair(input logic [15:0] a, input logic [15:0] b);
        in_valid = 1'b1; in_a = a; in_b = b;
        tick();
        in_valid = 1'b0; in_a = 16'h0; in_b = 16'h0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; len = '0; c_init = 16'h0;
        in_valid = 1'b0; in_a = 16'h0; in_b = 16'h0; out_ready = 1'b0;
        tick(); tick();
        chk_flags("reset", 1'b0, 1'b0, 1'b0);
        chk("reset.out_result", out_result, 16'h0000);
        chk("reset.fma_c", fma_c, 16'h0000);
        chk("reset.fma_a", fma_a, 16'h0000);
        rst_n = 1'b1;
        tick();
        $display("step: reset released");

        // Basic 2-element dot product, back-to-back pairs.
        begin_run(5'd2, 16'h0000);
        chk_flags("basic.c1", 1'b1, 1'b1, 1'b0);
        chk("basic.c1.fma_c", fma_c, 16'h0000);
        pair(16'h3F80, 16'h4000);
        chk("basic.c2.acc", fma_c, 16'h4000);
        chk_flags("basic.c2", 1'b1, 1'b1, 1'b0);
        pair(16'h4000, 16'h4040);
        chk_flags("basic.c3", 1'b0, 1'b1, 1'b1);
        chk("basic.result", out_result, 16'h4100);
        chk("basic.ov", {15'b0, out_ov}, 16'h0000);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk_flags("basic.idle", 1'b0, 1'b0, 1'b0);
        $display("step: basic dot product result=%h", out_result);

        // Nonzero addend with two idle cycles between pairs.
        begin_run(5'd3, 16'h3F80);
        pair(16'h3F00, 16'h4000);
        tick();
        chk("gap.acc1", fma_c, 16'h4000);
        tick();
        chk("gap.acc2", fma_c, 16'h4000);
        chk_flags("gap.hold", 1'b1, 1'b1, 1'b0);
        pair(16'h3F00, 16'h4000);
        tick(); tick();
        chk("gap.acc3", fma_c, 16'h4040);
        chk_flags("gap.hold2", 1'b1, 1'b1, 1'b0);
        pair(16'h3F00, 16'h4000);
        chk_flags("gap.done", 1'b0, 1'b1, 1'b1);
        chk("gap.result", out_result, 16'h4080);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        $display("step: gapped run result=4080 expected");

        // Zero length, with in_valid asserted alongside start.
        in_valid = 1'b1; in_a = 16'h3F80; in_b = 16'h4000;
        begin_run(5'd0, 16'h4040);
        chk_flags("zero.c1", 1'b0, 1'b1, 1'b1);
        chk("zero.result", out_result, 16'h4040);
        chk("zero.ov", {15'b0, out_ov}, 16'h0000);
        chk("zero.fma_a", fma_a, 16'h0000);
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk_flags("zero.idle", 1'b0, 1'b0, 1'b0);
        $display("step: zero-length run");

        // Sticky overflow, then backpressure with an ignored start pulse.
        begin_run(5'd2, 16'h0000);
        pair(16'h7F00, 16'h7F00);
        pair(16'h3F80, 16'h3F80);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin start = 1'b1; len = 5'd0; c_init = 16'h1234; end
            chk_flags("bp.hold", 1'b0, 1'b1, 1'b1);
            chk("bp.result", out_result, 16'h7F80);
            chk("bp.ov", {15'b0, out_ov}, 16'h0001);
            tick();
            start = 1'b0;
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk_flags("bp.idle", 1'b0, 1'b0, 1'b0);
        $display("step: overflow/backpressure run");

        // Reset after the first of four pairs.
        begin_run(5'd4, 16'h0000);
        pair(16'h3F80, 16'h4000);
        chk("rst.pre.acc", fma_c, 16'h4000);
        #2 rst_n = 1'b0;
        #1;
        chk_flags("rst.async", 1'b0, 1'b0, 1'b0);
        chk("rst.acc", fma_c, 16'h0000);
        chk("rst.out_result", out_result, 16'h0000);
        chk("rst.ov", {15'b0, out_ov}, 16'h0000);
        tick(); tick();
        chk_flags("rst.held", 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();
        chk_flags("rst.after", 1'b0, 1'b0, 1'b0);
        begin_run(5'd1, 16'h0000);
        pair(16'h4000, 16'h4040);
        chk_flags("rst.fresh", 1'b0, 1'b1, 1'b1);
        chk("rst.fresh.result", out_result, 16'h40C0);
        chk("rst.fresh.ov", {15'b0, out_ov}, 16'h0000);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        $display("step: reset mid-run and fresh run");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bf16_dot_seq.md
# bf16_dot_seq

Sequencing stage placed directly around the combinational bfloat16 fused multiply-add (FMA) datapath. It accepts a stream of (a, b) bfloat16 operand pairs and drives them into the FMA each cycle, feeding back its own accumulator as the addend. It registers each FMA result as the new accumulator and, after a programmed count of pairs, presents the final dot-product sum with a sticky overflow flag. The FMA itself stays external. This block owns all sequential behaviour: handshakes, element counter, accumulator and output holding.

## Interface
Parameters:
- LEN_W, default 5: width of the element-count field; maximum vector length is 2^LEN_W − 1.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset. Asserts immediately; deasserts synchronously to clk.
- start  input  1  one-cycle request to begin a new dot product; sampled only in IDLE.
- len  input  LEN_W  number of (a, b) pairs; sampled with start.
- c_init  input  16  initial accumulator value (bf16); sampled with start.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block accepts a pair this cycle.
- in_a, in_b  input  16 each  operand pair (bf16).
- fma_a, fma_b, fma_c  output  16 each  operands driven to the external FMA, which computes a*b+c.
- fma_result  input  16  FMA sum (bf16), combinational from fma_a/b/c.
- fma_ov  input  1  FMA overflow indication for the current operands.
- busy  output  1  high in any state other than IDLE.
- out_valid  output  1  final result valid.
- out_ready  input  1  consumer accepts the result.
- out_result  output  16  final accumulator value.
- out_ov  output  1  OR of fma_ov over every accepted pair.

## Operation
- FSM has three states: IDLE, RUN and DONE. The encoding is free.
- **IDLE**
  - On start=1 the block loads acc←c_init, cnt←len and ov_st←0.
  - If len≠0 it moves to RUN; if len=0 it moves directly to DONE.
- **RUN**
  - in_ready=1.
  - fma_a=in_a, fma_b=in_b, fma_c=acc.
  - A pair is accepted when in_valid & in_ready. On acceptance: acc←fma_result, ov_st←ov_st | fma_ov, cnt←cnt−1.
  - On the acceptance where cnt=1, the next state is DONE.
  - Cycles without in_valid leave acc, cnt and ov_st unchanged. Gaps are unlimited.
- **DONE**
  - out_valid=1, out_result=acc, out_ov=ov_st. These values are held stable until out_ready=1, then the block returns to IDLE.
  - start is ignored in DONE and in RUN.
- Outside RUN: in_ready=0, fma_a=fma_b=16'h0000, fma_c=acc.
- The block does not interpret bfloat16 values. All arithmetic is the external FMA's. The only counting is cnt, which is LEN_W bits and never wraps because DONE is entered at 1.

## Timing
- Reset values: state=IDLE, acc=16'h0000, cnt=0, ov_st=0. This gives in_ready=0, busy=0, out_valid=0, out_result=16'h0000, out_ov=0, fma_a=fma_b=fma_c=16'h0000.
- in_ready, busy and out_valid are decoded from registered state only, with no combinational path from in_valid or out_ready.
- Latency:
  - start is sampled at edge 0; in_ready is high from cycle 1.
  - Each pair takes one cycle at full throughput.
  - If the last pair is accepted at edge k, out_valid is high from cycle k+1.
  - For len=0, out_valid is high from cycle 1 with out_result=c_init and out_ov=0.
- A new start can be sampled no earlier than the cycle after the out_valid&out_ready handshake, because the block is in IDLE only from then on.
- With out_ready held high in DONE, out_valid lasts exactly one cycle.
- Reset asserted mid-RUN or in DONE returns the block to the reset values immediately. A partial result is discarded and never presented.
- If start and in_valid occur together in IDLE, in_valid is ignored because in_ready=0.

## Test plan
- **Basic 2-element dot product.** len=2, c_init=0x0000, pairs (0x3F80,0x4000) then (0x4000,0x4040) back-to-back → out_result=0x4100 (8.0), out_ov=0, out_valid 3 cycles after start.
- **Nonzero addend with input gaps.** len=3, c_init=0x3F80, pairs (0x3F00,0x4000)×3 with in_valid low for 2 cycles between each pair → out_result=0x4080 (4.0). Accumulator and cnt must be unchanged during the gaps.
- **Zero length.** len=0, c_init=0x4040 → out_valid in cycle 1, out_result=0x4040, out_ov=0, no pair accepted (in_ready never high).
- **Sticky overflow.** len=2, first pair (0x7F00,0x7F00) with the FMA raising fma_ov, second pair (0x3F80,0x3F80) → out_ov=1 at DONE.
- **Output backpressure and ignored start.** Hold out_ready=0 for 5 cycles in DONE → out_valid, out_result and out_ov stable. Pulse start during this window → ignored (state, cnt and acc unchanged). Raise out_ready → IDLE next cycle.
- **Reset mid-run.** Assert rst_n=0 after 1 of 4 pairs → all outputs at reset values within the same cycle, no out_valid. A fresh run after reset produces a correct result.
